// File: rtl/fracbrg_prog_if.sv
// fracbrg_prog_if: control, divisor-load and strobe bundle between the UART register file and the baud generator.
// Latency: none; this is wiring only.
// Backpressure: none. The master side drives the controls and divisor load, and the slave side returns the strobes.
// Signals: en_i/clr_i/sync_i controls, div_i + div_ld_i divisor load, and the div_pend_o/stb_o/bit_stb_o/clk_o outputs.
// FRACBRG_MIDSTB_EN adds mid_stb_o, the mid-bit sample strobe.
interface fracbrg_prog_if #(
    parameter int RESOLUTION = 16
);
    logic                  en_i;
    logic                  clr_i;
    logic                  sync_i;
    logic [RESOLUTION-1:0] div_i;
    logic                  div_ld_i;
    logic                  div_pend_o;
    logic                  stb_o;
    logic                  bit_stb_o;
    logic                  clk_o;
`ifdef FRACBRG_MIDSTB_EN
    logic                  mid_stb_o;

    modport master (
        output en_i, clr_i, sync_i, div_i, div_ld_i,
        input  div_pend_o, stb_o, bit_stb_o, clk_o, mid_stb_o
    );
    modport slave (
        input  en_i, clr_i, sync_i, div_i, div_ld_i,
        output div_pend_o, stb_o, bit_stb_o, clk_o, mid_stb_o
    );
`else
    modport master (
        output en_i, clr_i, sync_i, div_i, div_ld_i,
        input  div_pend_o, stb_o, bit_stb_o, clk_o
    );
    modport slave (
        input  en_i, clr_i, sync_i, div_i, div_ld_i,
        output div_pend_o, stb_o, bit_stb_o, clk_o
    );
`endif
endinterface

// File: rtl/fracbrg_prog.sv
// fracbrg_prog: runtime-programmable fractional baud generator (phase accumulator -> oversample strobe -> bit strobe).
// Latency: strobes are registered one cycle after the overflowing addition. A divisor load applies at the next overflow.
// Backpressure: none. en_i=0 freezes, clr_i clears, sync_i re-centres the oversample phase.
// Ports: clk_i, rst_i (synchronous, active-high); bus (fracbrg_prog_if.slave) carries the controls, div load and strobes.
// Optional: define FRACBRG_MIDSTB_EN to add bus.mid_stb_o, which marks the mid-bit RX sample point.
module fracbrg_prog #(
    parameter int RESOLUTION = 16,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_RST    = 1677
) (
    input  logic          clk_i,
    input  logic          rst_i,
    fracbrg_prog_if.slave bus
);
    localparam int                    OS_W     = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0]       OS_LAST  = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]       OS_HALF  = OS_W'(OVERSAMPLE / 2);
    localparam logic [RESOLUTION-1:0] DIV_INIT = RESOLUTION'(DIV_RST);
`ifdef FRACBRG_MIDSTB_EN
    localparam logic [OS_W-1:0]       OS_MID   = OS_W'(OVERSAMPLE / 2 - 1);
`endif

    logic [RESOLUTION-1:0] acc_q, acc_d;
    logic [RESOLUTION-1:0] div_act_q, div_act_d;
    logic [RESOLUTION-1:0] div_pend_q, div_pend_d;
    logic                  pend_q, pend_d;
    logic [OS_W-1:0]       os_cnt_q, os_cnt_d;
    logic                  stb_q, stb_d;
    logic                  bit_stb_q, bit_stb_d;
    logic                  clk_q, clk_d;
`ifdef FRACBRG_MIDSTB_EN
    logic                  mid_stb_q, mid_stb_d;
`endif

    logic [RESOLUTION:0]   sum;
    logic                  cy;
    logic                  run;
    logic                  apply;

    // The effective increment is div_act+1. This lets the all-ones divisor produce a strobe every cycle.
    assign sum = {1'b0, acc_q} + {1'b0, div_act_q} + {{RESOLUTION{1'b0}}, 1'b1};
    assign cy  = sum[RESOLUTION];
    assign run = bus.en_i & ~bus.clr_i & ~bus.sync_i;
    // A divisor swap happens only at a phase boundary (overflow) or while the accumulator is not free-running.
    // This keeps the interval in progress intact.
    assign apply = (run & cy) | ~bus.en_i | bus.clr_i | bus.sync_i;

    always_comb begin
        acc_d      = acc_q;
        os_cnt_d   = os_cnt_q;
        div_act_d  = div_act_q;
        div_pend_d = div_pend_q;
        pend_d     = pend_q;
        stb_d      = 1'b0;
        bit_stb_d  = 1'b0;
        // clk_o follows every emitted stb_o, including one that is visible during a freeze or sync cycle.
        clk_d      = clk_q ^ stb_q;
`ifdef FRACBRG_MIDSTB_EN
        mid_stb_d  = 1'b0;
`endif

        if (bus.clr_i) begin
            acc_d    = '0;
            os_cnt_d = '0;
            clk_d    = 1'b0;
        end else if (bus.sync_i) begin
            // Half a bit of phase: the next bit strobe lands mid-bit relative to the detected start edge.
            acc_d    = '0;
            os_cnt_d = OS_HALF;
        end else if (bus.en_i) begin
            acc_d     = sum[RESOLUTION-1:0];
            stb_d     = cy;
            bit_stb_d = cy & (os_cnt_q == OS_LAST);
`ifdef FRACBRG_MIDSTB_EN
            mid_stb_d = cy & (os_cnt_q == OS_MID);
`endif
            if (cy) begin
                os_cnt_d = (os_cnt_q == OS_LAST) ? '0 : os_cnt_q + OS_W'(1);
            end
        end

        if (bus.div_ld_i) begin
            if (apply) begin
                div_act_d = bus.div_i;
                pend_d    = 1'b0;
            end else begin
                div_pend_d = bus.div_i;
                pend_d     = 1'b1;
            end
        end else if (pend_q && apply) begin
            div_act_d = div_pend_q;
            pend_d    = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q      <= '0;
            os_cnt_q   <= '0;
            div_act_q  <= DIV_INIT;
            div_pend_q <= DIV_INIT;
            pend_q     <= 1'b0;
            stb_q      <= 1'b0;
            bit_stb_q  <= 1'b0;
            clk_q      <= 1'b0;
`ifdef FRACBRG_MIDSTB_EN
            mid_stb_q  <= 1'b0;
`endif
        end else begin
            acc_q      <= acc_d;
            os_cnt_q   <= os_cnt_d;
            div_act_q  <= div_act_d;
            div_pend_q <= div_pend_d;
            pend_q     <= pend_d;
            stb_q      <= stb_d;
            bit_stb_q  <= bit_stb_d;
            clk_q      <= clk_d;
`ifdef FRACBRG_MIDSTB_EN
            mid_stb_q  <= mid_stb_d;
`endif
        end
    end

    assign bus.div_pend_o = pend_q;
    assign bus.stb_o      = stb_q;
    assign bus.bit_stb_o  = bit_stb_q;
    assign bus.clk_o      = clk_q;
`ifdef FRACBRG_MIDSTB_EN
    assign bus.mid_stb_o  = mid_stb_q;
`endif
endmodule

// File: tb/tb_fracbrg_prog.sv
// tb_fracbrg_prog: randomized and directed bench for fracbrg_prog with an arithmetic reference model.
// Latency: the model advances on each rising edge, and outputs are compared on the following falling edge.
// Backpressure: none. Inputs change only on falling edges.
`timescale 1ns/1ps
module tb_fracbrg_prog;
    localparam int     RES  = 16;
    localparam int     OS   = 16;
    localparam int     DIVR = 1677;
    localparam longint MOD  = longint'(1) << RES;

    logic clk_i = 1'b0;
    logic rst_i;

    fracbrg_prog_if #(.RESOLUTION(RES)) bus ();

    fracbrg_prog #(.RESOLUTION(RES), .OVERSAMPLE(OS), .DIV_RST(DIVR)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference state: phase as an integer modulo 2^RES, bit position as an integer modulo OS.
    bit     m_valid = 1'b0;
    longint m_acc, m_div, m_pdiv;
    int     m_os;
    bit     m_pend, m_stb, m_bit, m_clk;
`ifdef FRACBRG_MIDSTB_EN
    bit     m_mid;
`endif

    int   stb_cnt, stb_last, stb_gmin, stb_gmax;
    int   bit_cnt, bit_last, bit_gmin, bit_gmax;
    int   rise_last, rise_gmin, rise_gmax;
    logic clk_o_prev = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_step();
        longint total;
        bit     carry, apply;
        if (rst_i) begin
            m_acc = 0; m_os = 0; m_div = DIVR; m_pdiv = DIVR; m_pend = 0;
            m_stb = 0; m_bit = 0; m_clk = 0;
`ifdef FRACBRG_MIDSTB_EN
            m_mid = 0;
`endif
            m_valid = 1'b1;
            return;
        end
        total = m_acc + m_div + 1;
        carry = bus.en_i && !bus.clr_i && !bus.sync_i && (total >= MOD);
        apply = carry || !bus.en_i || bus.clr_i || bus.sync_i;
        m_clk = bus.clr_i ? 1'b0 : (m_clk ^ m_stb);
        m_stb = 0; m_bit = 0;
`ifdef FRACBRG_MIDSTB_EN
        m_mid = 0;
`endif
        if (bus.clr_i) begin
            m_acc = 0; m_os = 0;
        end else if (bus.sync_i) begin
            m_acc = 0; m_os = OS / 2;
        end else if (bus.en_i) begin
            m_acc = total % MOD;
            if (carry) begin
                m_stb = 1;
                m_bit = (m_os == OS - 1);
`ifdef FRACBRG_MIDSTB_EN
                m_mid = (m_os == OS / 2 - 1);
`endif
                m_os = (m_os + 1) % OS;
            end
        end
        if (bus.div_ld_i) begin
            if (apply) begin m_div = bus.div_i; m_pend = 0; end
            else begin m_pdiv = bus.div_i; m_pend = 1; end
        end else if (m_pend && apply) begin
            m_div = m_pdiv; m_pend = 0;
        end
    endtask

    task automatic meas_start();
        stb_cnt = 0; stb_last = cyc; stb_gmin = 1 << 30; stb_gmax = 0;
        bit_cnt = 0; bit_last = cyc; bit_gmin = 1 << 30; bit_gmax = 0;
        rise_last = -1; rise_gmin = 1 << 30; rise_gmax = 0;
    endtask

    task automatic tick();
        int g;
        @(posedge clk_i);
        model_step();
        @(negedge clk_i);
        cyc++;
        if (m_valid) begin
            check("stb_o",      bus.stb_o,      m_stb);
            check("bit_stb_o",  bus.bit_stb_o,  m_bit);
            check("clk_o",      bus.clk_o,      m_clk);
            check("div_pend_o", bus.div_pend_o, m_pend);
            check("acc",        dut.acc_q,      m_acc);
            check("os_cnt",     dut.os_cnt_q,   m_os);
`ifdef FRACBRG_MIDSTB_EN
            check("mid_stb_o",  bus.mid_stb_o,  m_mid);
`endif
        end
        if (bus.stb_o === 1'b1) begin
            g = cyc - stb_last; stb_last = cyc; stb_cnt++;
            if (g < stb_gmin) stb_gmin = g;
            if (g > stb_gmax) stb_gmax = g;
        end
        if (bus.bit_stb_o === 1'b1) begin
            g = cyc - bit_last; bit_last = cyc; bit_cnt++;
            if (g < bit_gmin) bit_gmin = g;
            if (g > bit_gmax) bit_gmax = g;
        end
        if (bus.clk_o === 1'b1 && clk_o_prev === 1'b0) begin
            if (rise_last >= 0) begin
                g = cyc - rise_last;
                if (g < rise_gmin) rise_gmin = g;
                if (g > rise_gmax) rise_gmax = g;
            end
            rise_last = cyc;
        end
        clk_o_prev = bus.clk_o;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // which: 0 = stb_o, 1 = bit_stb_o, 2 = mid_stb_o
    task automatic wait_for(input int which, input int maxc, output int n);
        bit found;
        found = 1'b0;
        n = 0;
        while (!found && n < maxc) begin
            tick();
            n++;
            case (which)
                0:       found = (bus.stb_o === 1'b1);
                1:       found = (bus.bit_stb_o === 1'b1);
`ifdef FRACBRG_MIDSTB_EN
                2:       found = (bus.mid_stb_o === 1'b1);
`endif
                default: found = 1'b0;
            endcase
        end
        check("strobe within bound", found, 1);
    endtask

    // With en_i low the apply condition holds, so the value goes straight to the active divisor.
    task automatic load_direct(input logic [RES-1:0] v);
        bus.en_i = 0; bus.div_ld_i = 1; bus.div_i = v;
        tick();
        bus.div_ld_i = 0;
    endtask

    task automatic clear_start();
        bus.clr_i = 1;
        tick();
        bus.clr_i = 0; bus.en_i = 1;
    endtask

    int n, t0;

    initial begin
        rst_i = 1; bus.en_i = 0; bus.clr_i = 0; bus.sync_i = 0; bus.div_ld_i = 0; bus.div_i = '0;
        run(2);
        rst_i = 0;
        check("reset stb_o", bus.stb_o, 0);
        check("reset bit_stb_o", bus.bit_stb_o, 0);
        check("reset clk_o", bus.clk_o, 0);
        check("reset div_pend_o", bus.div_pend_o, 0);
        check("reset div_act (model)", m_div, 1677);
        check("reset div_act (dut)", dut.div_act_q, 1677);

        // Rate: inc 0x1000 gives stb every 16, bit every 256, clk_o period 32.
        load_direct(16'h0FFF);
        check("direct load leaves nothing pending", bus.div_pend_o, 0);
        clear_start();
        check("clr forces clk_o low", bus.clk_o, 0);
        meas_start();
        run(600);
        check("rate stb count", stb_cnt, 37);
        check("rate stb gap min", stb_gmin, 16);
        check("rate stb gap max", stb_gmax, 16);
        check("rate bit count", bit_cnt, 2);
        check("rate bit gap", bit_gmax, 256);
        check("rate clk_o period min", rise_gmin, 32);
        check("rate clk_o period max", rise_gmax, 32);

        // Fractional: inc 0x1800 gives 3 strobes per 32 clk, gaps of 10 or 11.
        load_direct(16'h17FF);
        clear_start();
        meas_start();
        run(3200);
        check("frac stb count", stb_cnt, 300);
        check("frac gap min", stb_gmin, 10);
        check("frac gap max", stb_gmax, 11);

        // Glitch-free load mid-interval.
        load_direct(16'h0FFF);
        clear_start();
        wait_for(0, 40, n);
        run(5);
        bus.div_ld_i = 1; bus.div_i = 16'h7FFF;
        tick();
        bus.div_ld_i = 0;
        check("load pending mid-interval", bus.div_pend_o, 1);
        wait_for(0, 40, n);
        check("interval in progress kept", n + 6, 16);
        check("pending cleared at stb", bus.div_pend_o, 0);
        meas_start();
        run(40);
        check("new rate stb count", stb_cnt, 20);
        check("new rate gap min", stb_gmin, 2);
        check("new rate gap max", stb_gmax, 2);

        // Sync re-centre at the maximum rate.
        load_direct(16'hFFFF);
        bus.en_i = 1;
        run(10);
        t0 = cyc;
        bus.sync_i = 1;
        tick();
        bus.sync_i = 0;
        check("sync suppresses stb_o", bus.stb_o, 0);
        check("sync suppresses bit_stb_o", bus.bit_stb_o, 0);
        wait_for(1, 40, n);
        check("sync to first bit_stb", cyc - t0, 9);
`ifdef FRACBRG_MIDSTB_EN
        t0 = cyc;
        bus.sync_i = 1;
        tick();
        bus.sync_i = 0;
        wait_for(2, 40, n);
        check("sync to first mid_stb", cyc - t0, 17);
`endif

        // Freeze holds phase, and resume finishes the interval.
        load_direct(16'h0FFF);
        clear_start();
        run(7);
        bus.en_i = 0;
        meas_start();
        run(50);
        check("freeze no strobes", stb_cnt, 0);
        check("freeze acc held", dut.acc_q, 16'h7000);
        check("freeze os_cnt held", dut.os_cnt_q, 0);
        bus.en_i = 1;
        wait_for(0, 40, n);
        check("resume completes interval", n, 9);

        // Random traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            rst_i        = ($urandom_range(0, 299) == 0);
            bus.clr_i    = ($urandom_range(0, 39) == 0);
            bus.sync_i   = ($urandom_range(0, 39) == 0);
            bus.en_i     = ($urandom_range(0, 9) != 0);
            bus.div_ld_i = ($urandom_range(0, 19) == 0);
            bus.div_i    = ($urandom_range(0, 3) == 0) ? RES'($urandom_range(16'hF000, 16'hFFFF))
                                                       : RES'($urandom);
            tick();
        end
        rst_i = 0; bus.clr_i = 0; bus.sync_i = 0; bus.div_ld_i = 0;

        // Reset while a load is pending.
        load_direct(16'h0FFF);
        clear_start();
        run(3);
        bus.div_ld_i = 1; bus.div_i = 16'h0100;
        tick();
        bus.div_ld_i = 0;
        check("pending before reset", bus.div_pend_o, 1);
        rst_i = 1;
        tick();
        rst_i = 0;
        check("reset clears pending", bus.div_pend_o, 0);
        check("reset restores div_act", dut.div_act_q, 1677);
        meas_start();
        run(2500);
        check("reset-rate stb count", stb_cnt, 64);
        check("reset-rate bit count", bit_cnt, 4);
        check("reset-rate bit period 625+-1", (bit_gmin >= 624) && (bit_gmax <= 626), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end
endmodule
